id_ex_stage: RTL and testbench

//  ID->EX pipeline register of the MIPS32 core. Captures both register-bank read ports plus decoded

---
 rtl/id_ex_stage.sv | 101 ++++++++++
 tb/tb_id_ex_stage.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register with operand forwarding and load-use bubbles; IDEX_PERF_CNT_EN adds BUBBLE_CNT
module id_ex_stage #(
  parameter int WORD_LEN = 32,
  parameter int REG_ADDR_LEN = 5,
  parameter int ALU_OP_LEN = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    STALL,
  input  logic                    FLUSH,
  input  logic                    ID_VALID,
  input  logic [WORD_LEN-1:0]     ID_PC,
  input  logic [REG_ADDR_LEN-1:0] RS_ADDR,
  input  logic [REG_ADDR_LEN-1:0] RT_ADDR,
  input  logic [REG_ADDR_LEN-1:0] RD_ADDR,
  input  logic [WORD_LEN-1:0]     RS_DATA,
  input  logic [WORD_LEN-1:0]     RT_DATA,
  input  logic [WORD_LEN-1:0]     ID_IMM,
  input  logic [ALU_OP_LEN-1:0]   ID_ALU_OP,
  input  logic                    ID_MEM_READ,
  input  logic                    ID_MEM_WRITE,
  input  logic                    ID_WB_EN,
  input  logic                    F1_WB_EN,
  input  logic [REG_ADDR_LEN-1:0] F1_RD,
  input  logic [WORD_LEN-1:0]     F1_DATA,
  input  logic                    F2_WB_EN,
  input  logic [REG_ADDR_LEN-1:0] F2_RD,
  input  logic [WORD_LEN-1:0]     F2_DATA,
  output logic                    EX_VALID,
  output logic [WORD_LEN-1:0]     EX_PC,
  output logic [WORD_LEN-1:0]     EX_A,
  output logic [WORD_LEN-1:0]     EX_B,
  output logic [WORD_LEN-1:0]     EX_IMM,
  output logic [REG_ADDR_LEN-1:0] EX_RD,
  output logic [ALU_OP_LEN-1:0]   EX_ALU_OP,
  output logic                    EX_MEM_READ,
  output logic                    EX_MEM_WRITE,
  output logic                    EX_WB_EN,
`ifdef IDEX_PERF_CNT_EN
  output logic [31:0]             BUBBLE_CNT,
`endif
  output logic                    ID_HOLD
);
  logic                    valid_q, valid_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d, wb_en_q, wb_en_d;
  logic [WORD_LEN-1:0]     pc_q, pc_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [REG_ADDR_LEN-1:0] rd_q, rd_d;
  logic [ALU_OP_LEN-1:0]   alu_op_q, alu_op_d;
  logic                    hz, keep, cap, bubble;
  function automatic logic [WORD_LEN-1:0] fwd(input logic [REG_ADDR_LEN-1:0] addr, input logic [WORD_LEN-1:0] rdata);
    return (F1_WB_EN && F1_RD != '0 && F1_RD == addr) ? F1_DATA
         : (F2_WB_EN && F2_RD != '0 && F2_RD == addr) ? F2_DATA : rdata;
  endfunction
  // hazard detection, update selection and next-state of the EX bundle
  always_comb begin
    hz = valid_q && mem_read_q && rd_q != '0 && ID_VALID && (rd_q == RS_ADDR || rd_q == RT_ADDR);
    keep = STALL && !FLUSH;
    cap = !FLUSH && !STALL && !hz;
    bubble = FLUSH || (!STALL && hz);
    ID_HOLD = !RESET && !FLUSH && (STALL || hz);
    valid_d = keep ? valid_q : cap && ID_VALID;
    pc_d = keep ? pc_q : cap ? ID_PC : '0;
    a_d = keep ? a_q : cap ? fwd(RS_ADDR, RS_DATA) : '0;
    b_d = keep ? b_q : cap ? fwd(RT_ADDR, RT_DATA) : '0;
    imm_d = keep ? imm_q : cap ? ID_IMM : '0;
    rd_d = keep ? rd_q : cap ? RD_ADDR : '0;
    alu_op_d = keep ? alu_op_q : cap ? ID_ALU_OP : '0;
    mem_read_d = keep ? mem_read_q : cap && ID_VALID && ID_MEM_READ;
    mem_write_d = keep ? mem_write_q : cap && ID_VALID && ID_MEM_WRITE;
    wb_en_d = keep ? wb_en_q : cap && ID_VALID && ID_WB_EN;
  end
  // EX bundle register with synchronous clear
  always_ff @(posedge CLK) begin
    if (RESET) begin
      {valid_q, pc_q, a_q, b_q, imm_q, rd_q, alu_op_q, mem_read_q, mem_write_q, wb_en_q} <= '0;
    end else begin
      {valid_q, pc_q, a_q, b_q, imm_q, rd_q, alu_op_q, mem_read_q, mem_write_q, wb_en_q} <=
        {valid_d, pc_d, a_d, b_d, imm_d, rd_d, alu_op_d, mem_read_d, mem_write_d, wb_en_d};
    end
  end
  assign EX_VALID = valid_q;
  assign EX_PC = pc_q;
  assign EX_A = a_q;
  assign EX_B = b_q;
  assign EX_IMM = imm_q;
  assign EX_RD = rd_q;
  assign EX_ALU_OP = alu_op_q;
  assign EX_MEM_READ = mem_read_q;
  assign EX_MEM_WRITE = mem_write_q;
  assign EX_WB_EN = wb_en_q;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  // count every inserted bubble, wrapping naturally
  always_comb bubble_cnt_d = bubble_cnt_q + 32'(bubble);
  // counter register
  always_ff @(posedge CLK) bubble_cnt_q <= RESET ? '0 : bubble_cnt_d;
  assign BUBBLE_CNT = bubble_cnt_q;
`else
  logic unused_bubble;
  assign unused_bubble = bubble;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table vectors, directed hazard/stall sequences and random stimulus against a rule-level model
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst, stall, flush, id_valid, id_mem_read, id_mem_write, id_wb_en, f1_wb_en, f2_wb_en;
  logic [31:0] id_pc, rs_data, rt_data, id_imm, f1_data, f2_data;
  logic [4:0] rs_addr, rt_addr, rd_addr, f1_rd, f2_rd;
  logic [3:0] id_alu_op;
  logic ex_valid, ex_mem_read, ex_mem_write, ex_wb_en, id_hold;
  logic [31:0] ex_pc, ex_a, ex_b, ex_imm, bubble_cnt;
  logic [4:0] ex_rd;
  logic [3:0] ex_alu_op;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  id_ex_stage dut (
    .CLK(clk), .RESET(rst), .STALL(stall), .FLUSH(flush), .ID_VALID(id_valid), .ID_PC(id_pc),
    .RS_ADDR(rs_addr), .RT_ADDR(rt_addr), .RD_ADDR(rd_addr), .RS_DATA(rs_data), .RT_DATA(rt_data),
    .ID_IMM(id_imm), .ID_ALU_OP(id_alu_op), .ID_MEM_READ(id_mem_read), .ID_MEM_WRITE(id_mem_write),
    .ID_WB_EN(id_wb_en), .F1_WB_EN(f1_wb_en), .F1_RD(f1_rd), .F1_DATA(f1_data),
    .F2_WB_EN(f2_wb_en), .F2_RD(f2_rd), .F2_DATA(f2_data),
    .EX_VALID(ex_valid), .EX_PC(ex_pc), .EX_A(ex_a), .EX_B(ex_b), .EX_IMM(ex_imm), .EX_RD(ex_rd),
    .EX_ALU_OP(ex_alu_op), .EX_MEM_READ(ex_mem_read), .EX_MEM_WRITE(ex_mem_write), .EX_WB_EN(ex_wb_en),
`ifdef IDEX_PERF_CNT_EN
    .BUBBLE_CNT(bubble_cnt),
`endif
    .ID_HOLD(id_hold)
  );
`ifndef IDEX_PERF_CNT_EN
  assign bubble_cnt = '0;
`endif
  typedef struct packed {
    logic v; logic [31:0] pc, a, b, imm; logic [4:0] rd; logic [3:0] op; logic mr, mw, wb;
  } ex_t;
  ex_t m;
  logic [31:0] m_cnt;
  typedef struct {
    logic [4:0] rs, rt; logic [31:0] rsd, rtd;
    logic f1e; logic [4:0] f1r; logic [31:0] f1d;
    logic f2e; logic [4:0] f2r; logic [31:0] f2d;
    logic [31:0] ea, eb;
  } vec_t;
  vec_t tbl[6];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // forwarding source search: youngest matching nonzero writer first, else register file
  function automatic logic [31:0] src(input logic [4:0] addr, input logic [31:0] rf);
    logic [4:0] rds[2]; logic ens[2]; logic [31:0] ds[2];
    rds = '{f1_rd, f2_rd}; ens = '{f1_wb_en, f2_wb_en}; ds = '{f1_data, f2_data};
    if (addr == 5'd0) return rf;
    for (int i = 0; i < 2; i++) if (ens[i] && rds[i] == addr) return ds[i];
    return rf;
  endfunction
  function automatic logic load_use();
    return m.v && m.mr && m.rd != 5'd0 && id_valid && (m.rd == rs_addr || m.rd == rt_addr);
  endfunction
  task automatic cmp_all(input string tag);
    chk({tag, ".valid"}, 32'(ex_valid), 32'(m.v));
    chk({tag, ".pc"}, ex_pc, m.pc);
    chk({tag, ".a"}, ex_a, m.a);
    chk({tag, ".b"}, ex_b, m.b);
    chk({tag, ".imm"}, ex_imm, m.imm);
    chk({tag, ".rd"}, 32'(ex_rd), 32'(m.rd));
    chk({tag, ".op"}, 32'(ex_alu_op), 32'(m.op));
    chk({tag, ".ctl"}, 32'({ex_mem_read, ex_mem_write, ex_wb_en}), 32'({m.mr, m.mw, m.wb}));
`ifdef IDEX_PERF_CNT_EN
    chk({tag, ".cnt"}, bubble_cnt, m_cnt);
`endif
  endtask
  // one clock: check ID_HOLD, advance model by the priority rules, compare the EX bundle
  task automatic cyc(input string tag);
    ex_t nx;
    logic hz;
    hz = load_use();
    #1;
    chk({tag, ".hold"}, 32'(id_hold), 32'(!rst && !flush && (stall || hz)));
    nx = m;
    if (rst) begin nx = '0; m_cnt = 0; end
    else if (flush || (!stall && hz)) begin nx = '0; m_cnt = m_cnt + 1; end
    else if (!stall) nx = '{v: id_valid, pc: id_pc, a: src(rs_addr, rs_data), b: src(rt_addr, rt_data),
                            imm: id_imm, rd: rd_addr, op: id_alu_op, mr: id_valid & id_mem_read,
                            mw: id_valid & id_mem_write, wb: id_valid & id_wb_en};
    @(posedge clk);
    m = nx;
    #1;
    cmp_all(tag);
  endtask
  task automatic idle();
    {stall, flush, id_valid, id_mem_read, id_mem_write, id_wb_en, f1_wb_en, f2_wb_en} = '0;
    {id_pc, rs_data, rt_data, id_imm, f1_data, f2_data} = '0;
    {rs_addr, rt_addr, rd_addr, f1_rd, f2_rd, id_alu_op} = '0;
  endtask
  task automatic rnd_inputs(input bit ctl);
    id_valid = 1'($urandom); id_pc = $urandom; id_imm = $urandom; id_alu_op = 4'($urandom);
    rs_addr = 5'($urandom_range(0, 3)); rt_addr = 5'($urandom_range(0, 3)); rd_addr = 5'($urandom_range(0, 3));
    rs_data = $urandom; rt_data = $urandom; id_mem_read = ($urandom_range(0, 2) == 0);
    id_mem_write = 1'($urandom); id_wb_en = 1'($urandom);
    f1_wb_en = 1'($urandom); f1_rd = 5'($urandom_range(0, 3)); f1_data = $urandom;
    f2_wb_en = 1'($urandom); f2_rd = 5'($urandom_range(0, 3)); f2_data = $urandom;
    if (ctl) begin
      stall = ($urandom_range(0, 7) == 0); flush = ($urandom_range(0, 9) == 0); rst = ($urandom_range(0, 49) == 0);
    end
  endtask
  initial begin
    m = '0; m_cnt = 0;
    tbl[0] = '{5'd5, 5'd6, 32'h1, 32'h2, 1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB, 32'hAAAA, 32'h2};
    tbl[1] = '{5'd5, 5'd6, 32'h1, 32'h2, 1'b0, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB, 32'hBBBB, 32'h2};
    tbl[2] = '{5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h5678, 32'h0, 32'h0};
    tbl[3] = '{5'd7, 5'd7, 32'h9, 32'h9, 1'b0, 5'd7, 32'h1, 1'b1, 5'd7, 32'hCAFE, 32'hCAFE, 32'hCAFE};
    tbl[4] = '{5'd3, 5'd4, 32'h5, 32'h6, 1'b1, 5'd4, 32'h11, 1'b1, 5'd3, 32'h22, 32'h22, 32'h11};
    tbl[5] = '{5'd2, 5'd2, 32'h33, 32'h33, 1'b1, 5'd9, 32'h1, 1'b1, 5'd10, 32'h2, 32'h33, 32'h33};
    idle();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rnd_inputs(1'b0); stall = 1'b1; rst = 1'b1;
      cyc("reset");
      chk("reset.zero", 32'({ex_valid, ex_mem_read, ex_mem_write, ex_wb_en}) | ex_pc | ex_a | ex_b, 32'h0);
    end
    idle(); rst = 1'b0;
    id_valid = 1'b1; id_pc = 32'h400; rs_addr = 5'd1; rs_data = 32'h77; id_wb_en = 1'b1; rd_addr = 5'd9;
    cyc("release");
    chk("release.pc", ex_pc, 32'h400);
    chk("release.valid", 32'(ex_valid), 32'h1);
    foreach (tbl[i]) begin
      idle(); id_valid = 1'b1; id_pc = 32'(i);
      {rs_addr, rt_addr, rs_data, rt_data} = {tbl[i].rs, tbl[i].rt, tbl[i].rsd, tbl[i].rtd};
      {f1_wb_en, f1_rd, f1_data} = {tbl[i].f1e, tbl[i].f1r, tbl[i].f1d};
      {f2_wb_en, f2_rd, f2_data} = {tbl[i].f2e, tbl[i].f2r, tbl[i].f2d};
      cyc("fwd");
      chk("fwd.a", ex_a, tbl[i].ea);
      chk("fwd.b", ex_b, tbl[i].eb);
    end
    idle(); rst = 1'b1; cyc("rst2"); rst = 1'b0;
    flush = 1'b1; id_valid = 1'b1; id_wb_en = 1'b1;
    cyc("flush");
    chk("flush.valid", 32'(ex_valid), 32'h0);
    idle(); id_valid = 1'b1; id_mem_read = 1'b1; id_wb_en = 1'b1; rd_addr = 5'd8; id_pc = 32'h100;
    cyc("lw");
    idle(); id_valid = 1'b1; rs_addr = 5'd8; rt_addr = 5'd2; rd_addr = 5'd3; id_wb_en = 1'b1; id_pc = 32'h104;
    #1 chk("lu.hold", 32'(id_hold), 32'h1);
    cyc("lu.bubble");
    chk("lu.bubble_valid", 32'(ex_valid), 32'h0);
    f1_wb_en = 1'b1; f1_rd = 5'd8; f1_data = 32'hDEAD;
    cyc("lu.add");
    chk("lu.add_a", ex_a, 32'hDEAD);
    chk("lu.add_pc", ex_pc, 32'h104);
`ifdef IDEX_PERF_CNT_EN
    chk("cnt.two", bubble_cnt, 32'd2);
`endif
    idle(); id_valid = 1'b1; id_mem_read = 1'b1; rd_addr = 5'd0; rs_addr = 5'd0; id_pc = 32'h200;
    cyc("lw0");
    cyc("lw0.dep");
    chk("lw0.nohz", 32'(ex_valid), 32'h1);
    idle(); id_valid = 1'b1; id_pc = 32'h300; rs_data = 32'h42; rs_addr = 5'd4;
    cyc("pre_stall");
    for (int i = 0; i < 3; i++) begin
      rnd_inputs(1'b0); stall = 1'b1;
      cyc("stall");
      chk("stall.pc", ex_pc, 32'h300);
      chk("stall.a", ex_a, 32'h42);
    end
    flush = 1'b1;
    cyc("stall_flush");
    chk("stall_flush.valid", 32'(ex_valid), 32'h0);
    idle();
    for (int i = 0; i < 400; i++) begin
      rnd_inputs(1'b1);
      cyc("rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
